// File: rtl/pipe_stage_skid.sv
// Generic pipeline boundary register with valid/ready handshake, optional 2-entry skid buffer,
// flush/bubble injection and saturating stall/bubble performance counters.
module pipe_stage_skid #(
  parameter int                 DATA_W     = 96,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter bit                 SKID       = 1'b1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inject,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_data_p0, main_data_d;
  logic               main_bub_p0, main_bub_d;
  logic [DATA_W-1:0]  skid_data_p1, skid_data_d;
  logic               skid_bub_p1, skid_bub_d;
  logic [CNT_W-1:0]   stall_cnt_q, bubble_cnt_q;

  logic               slot_avail, out_fire, acc_data, acc_bub, acc;
  logic [DATA_W-1:0]  entry_data;

  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_data_p0;
  assign out_bubble = main_bub_p0;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  // With the skid buffer, readiness depends only on registered state; without it,
  // a full register can still accept when the head drains this cycle.
  assign slot_avail = SKID ? (state_q != TWO) : (~out_valid | out_ready);
  assign out_fire   = out_valid & out_ready;
  assign in_ready   = slot_avail & ~inject & ~flush & ~rst;
  assign acc_data   = in_valid & in_ready;
  assign acc_bub    = inject & slot_avail & ~flush;
  assign acc        = acc_data | acc_bub;
  assign entry_data = acc_bub ? BUBBLE_VAL : in_data;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_p0;
    main_bub_d  = main_bub_p0;
    skid_data_d = skid_data_p1;
    skid_bub_d  = skid_bub_p1;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = BUBBLE_VAL;
      main_bub_d  = 1'b0;
      skid_data_d = BUBBLE_VAL;
      skid_bub_d  = 1'b0;
    end else if (SKID) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_data_d = entry_data;
            main_bub_d  = acc_bub;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (out_fire && acc) begin
            main_data_d = entry_data;
            main_bub_d  = acc_bub;
          end else if (out_fire) begin
            main_data_d = BUBBLE_VAL;
            main_bub_d  = 1'b0;
            state_d     = EMPTY;
          end else if (acc) begin
            skid_data_d = entry_data;
            skid_bub_d  = acc_bub;
            state_d     = TWO;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_data_d = skid_data_p1;
            main_bub_d  = skid_bub_p1;
            skid_data_d = BUBBLE_VAL;
            skid_bub_d  = 1'b0;
            state_d     = ONE;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = BUBBLE_VAL;
          main_bub_d  = 1'b0;
        end
      endcase
    end else begin
      if (acc) begin
        main_data_d = entry_data;
        main_bub_d  = acc_bub;
        state_d     = ONE;
      end else if (out_fire) begin
        main_data_d = BUBBLE_VAL;
        main_bub_d  = 1'b0;
        state_d     = EMPTY;
      end
    end
  end

  // Stage register boundary: head (p0) and skid (p1) entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_data_p0 <= BUBBLE_VAL;
      main_bub_p0  <= 1'b0;
      skid_data_p1 <= BUBBLE_VAL;
      skid_bub_p1  <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_p0 <= main_data_d;
      main_bub_p0  <= main_bub_d;
      skid_data_p1 <= skid_data_d;
      skid_bub_p1  <= skid_bub_d;
      if (out_valid && !out_ready)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (acc_bub)
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

endmodule
